// File: rtl/dmem_req_ctrl_pkg.sv
// ============================================================================
// Module  : dmem_req_ctrl_pkg
// Brief   : Shared encodings for the MEM-stage data-cache request controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_req_ctrl_pkg;

   // RV32 load/store funct3 codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [3:0] WE_READ = 4'b0000;

   typedef logic [1:0] state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_req_ctrl_if.sv
// ============================================================================
// Module  : dmem_req_ctrl_if
// Brief   : Valid/ready request and load-response bus to the data cache.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_req_ctrl_if #(
   parameter int ADDR_W = 32
) ();

   logic              dcache_req_valid;
   logic              dcache_req_ready;
   logic [3:0]        dcache_req_we;
   logic [ADDR_W-1:0] dcache_req_addr;
   logic [31:0]       dcache_req_wdata;
   logic              dcache_resp_valid;
   logic [31:0]       dcache_resp_data;

   modport master (
      output dcache_req_valid,
      output dcache_req_we,
      output dcache_req_addr,
      output dcache_req_wdata,
      input  dcache_req_ready,
      input  dcache_resp_valid,
      input  dcache_resp_data
   );

   modport slave (
      input  dcache_req_valid,
      input  dcache_req_we,
      input  dcache_req_addr,
      input  dcache_req_wdata,
      output dcache_req_ready,
      output dcache_resp_valid,
      output dcache_resp_data
   );

endinterface

`default_nettype wire

// File: rtl/dmem_req_ctrl_load_align_ext.sv
// ============================================================================
// Module  : load_align_ext
// Brief   : Shifts a loaded word to its byte offset and sign/zero-extends it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align_ext
   import dmem_req_ctrl_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted;

   assign shifted = word >> {offset, 3'b000};

   always_comb begin
      case (funct3)
         F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   data = {24'd0, shifted[7:0]};
         F3_HU:   data = {16'd0, shifted[15:0]};
         default: data = shifted;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dmem_req_ctrl.sv
// ============================================================================
// Module  : dmem_req_ctrl
// Brief   : MEM-stage data-cache initiator: issues load/store requests, stalls
//           the pipeline while outstanding and returns extended load data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_req_ctrl
   import dmem_req_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid_M,
   input  logic              mem_load_M,
   input  logic              mem_store_M,
   input  logic [2:0]        funct3_M,
   input  logic [ADDR_W-1:0] addr_M,
   input  logic [31:0]       store_data_M,
   dmem_req_ctrl_if.master   dc,
   output logic              stall,
   output logic [31:0]       load_data_M,
   output logic              misaligned_M,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic             op, go, misaligned;
   logic [1:0]       size;
   state_t           state_q, state_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [1:0]       offset_q, offset_d;
   logic [31:0]      word_q, word_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             req_valid, stall_int;
   logic [31:0]      aligned;

   assign op           = mem_valid_M & (mem_load_M | mem_store_M);
   assign size         = funct3_M[1:0];
   assign misaligned   = ((size == SZ_W) && (addr_M[1:0] != 2'b00)) ||
                         ((size == SZ_H) && addr_M[0]);
   assign misaligned_M = op & misaligned;
   assign go           = op & ~misaligned;

   always_comb begin
      state_d   = state_q;
      funct3_d  = funct3_q;
      offset_d  = offset_q;
      word_d    = word_q;
      req_valid = 1'b0;
      stall_int = 1'b0;
      case (state_q)
         ST_IDLE, ST_REQ: begin
            // REQ keeps requesting unconditionally: the stall holds the op stable
            if (go || (state_q == ST_REQ)) begin
               req_valid = 1'b1;
               stall_int = 1'b1;
               if (dc.dcache_req_ready) begin
                  if (mem_load_M) begin
                     state_d  = ST_WAIT;
                     funct3_d = funct3_M;
                     offset_d = addr_M[1:0];
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_WAIT: begin
            stall_int = 1'b1;
            if (dc.dcache_resp_valid) begin
               word_d  = dc.dcache_resp_data;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign stall               = stall_int & ~reset;
   assign dc.dcache_req_valid = req_valid & ~reset;
   assign dc.dcache_req_addr  = {addr_M[ADDR_W-1:2], 2'b00};
   assign stall_cnt_d         = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
   assign stall_cnt           = stall_cnt_q;

   always_comb begin
      dc.dcache_req_we    = WE_READ;
      dc.dcache_req_wdata = store_data_M;
      if (!mem_load_M) begin
         case (size)
            SZ_B: begin
               dc.dcache_req_we    = 4'b0001 << addr_M[1:0];
               dc.dcache_req_wdata = {4{store_data_M[7:0]}};
            end
            SZ_H: begin
               dc.dcache_req_we    = 4'b0011 << {addr_M[1], 1'b0};
               dc.dcache_req_wdata = {2{store_data_M[15:0]}};
            end
            default: dc.dcache_req_we = 4'b1111;
         endcase
      end
   end

   load_align_ext u_align (
      .word   (word_q),
      .offset (offset_q),
      .funct3 (funct3_q),
      .data   (aligned)
   );

   assign load_data_M = (state_q == ST_DONE) ? aligned : 32'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         funct3_q    <= 3'd0;
         offset_q    <= 2'd0;
         word_q      <= 32'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         funct3_q    <= funct3_d;
         offset_q    <= offset_d;
         word_q      <= word_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

`default_nettype wire
